// File: rtl/dram_axi_gate_ctrl.sv
// dram_axi_gate_ctrl: gates AW/AR/W until calibration, counts outstanding bursts, isolate/drain handshake (ports: clk_i/rst_i, calib/isolate control, status flags, AW/AR/W gated handshakes, B/R observed)
module dram_axi_gate_ctrl #(
  parameter int MaxOutstanding = 16,
  parameter int CalibTimeout = 1048576,
  parameter int CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                calib_done_i,
  input  logic                isolate_req_i,
  output logic                isolate_ack_o,
  output logic [1:0]          state_o,
  output logic                calib_timeout_o,
  output logic                calib_lost_o,
  output logic                protocol_err_o,
  output logic [CntWidth-1:0] rd_outstanding_o,
  output logic [CntWidth-1:0] wr_outstanding_o,
  input  logic                slv_aw_valid_i,
  output logic                slv_aw_ready_o,
  output logic                mst_aw_valid_o,
  input  logic                mst_aw_ready_i,
  input  logic                slv_ar_valid_i,
  output logic                slv_ar_ready_o,
  output logic                mst_ar_valid_o,
  input  logic                mst_ar_ready_i,
  input  logic                slv_w_valid_i,
  output logic                slv_w_ready_o,
  output logic                mst_w_valid_o,
  input  logic                mst_w_ready_i,
  input  logic                w_last_i,
  input  logic                mst_b_valid_i,
  input  logic                slv_b_ready_i,
  input  logic                mst_r_valid_i,
  input  logic                slv_r_ready_i,
  input  logic                r_last_i
);
  typedef enum logic [1:0] {CALIB, RUN, DRAIN, ISOLATED} state_t;
  localparam int TW = $clog2(CalibTimeout + 1);
  localparam logic [TW-1:0] CalLast = TW'(CalibTimeout - 1);
  localparam logic [CntWidth-1:0] MaxOut = CntWidth'(MaxOutstanding);
  state_t r_state, w_state_nxt, w_exit;
  logic [TW-1:0] r_calib_cnt, w_calib_cnt_nxt;
  logic [CntWidth-1:0] r_rd, r_wr, r_wpend;
  logic r_timeout, r_lost, r_perr;
  logic w_allow_aw, w_allow_ar, w_allow_w, w_idle;
  logic w_aw_fire, w_ar_fire, w_wl_fire, w_b_fire, w_r_fire;
  function automatic logic [CntWidth-1:0] cnt_nxt(input logic [CntWidth-1:0] c, input logic inc, input logic dec);
    return (inc == dec) ? c : inc ? c + CntWidth'(1) : (c == '0) ? c : c - CntWidth'(1);
  endfunction
  assign w_allow_aw = (r_state == RUN) && (r_wr < MaxOut);
  assign w_allow_ar = (r_state == RUN) && (r_rd < MaxOut);
  assign w_allow_w = (r_wpend != '0);
  assign mst_aw_valid_o = slv_aw_valid_i & w_allow_aw;
  assign slv_aw_ready_o = mst_aw_ready_i & w_allow_aw;
  assign mst_ar_valid_o = slv_ar_valid_i & w_allow_ar;
  assign slv_ar_ready_o = mst_ar_ready_i & w_allow_ar;
  assign mst_w_valid_o = slv_w_valid_i & w_allow_w;
  assign slv_w_ready_o = mst_w_ready_i & w_allow_w;
  assign w_aw_fire = slv_aw_valid_i & slv_aw_ready_o;
  assign w_ar_fire = slv_ar_valid_i & slv_ar_ready_o;
  assign w_wl_fire = slv_w_valid_i & slv_w_ready_o & w_last_i;
  assign w_b_fire = mst_b_valid_i & slv_b_ready_i;
  assign w_r_fire = mst_r_valid_i & slv_r_ready_i & r_last_i;
  assign w_idle = (r_rd == '0) && (r_wr == '0) && (r_wpend == '0);
  assign w_calib_cnt_nxt = (r_calib_cnt == CalLast) ? r_calib_cnt : r_calib_cnt + TW'(1);
  always_comb begin
    w_exit = isolate_req_i ? ISOLATED : calib_done_i ? RUN : CALIB;
    w_state_nxt = w_exit;
    if (r_state == RUN) w_state_nxt = (!calib_done_i || isolate_req_i) ? DRAIN : RUN;
    else if (r_state == DRAIN && !w_idle) w_state_nxt = DRAIN;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= CALIB;
      r_calib_cnt <= '0;
      r_rd <= '0;
      r_wr <= '0;
      r_wpend <= '0;
      r_timeout <= 1'b0;
      r_lost <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_calib_cnt <= (r_state == CALIB && w_state_nxt == CALIB) ? w_calib_cnt_nxt : '0;
      r_timeout <= r_timeout | (r_state == CALIB && w_calib_cnt_nxt == CalLast);
      r_lost <= r_lost | (r_state == RUN && !calib_done_i);
      r_perr <= r_perr | (w_b_fire && r_wr == '0) | (w_r_fire && r_rd == '0) | (w_wl_fire && r_wpend == '0);
      r_wr <= cnt_nxt(r_wr, w_aw_fire, w_b_fire);
      r_rd <= cnt_nxt(r_rd, w_ar_fire, w_r_fire);
      r_wpend <= cnt_nxt(r_wpend, w_aw_fire, w_wl_fire);
    end
  end
  assign state_o = r_state;
  assign isolate_ack_o = (r_state == ISOLATED);
  assign calib_timeout_o = r_timeout;
  assign calib_lost_o = r_lost;
  assign protocol_err_o = r_perr;
  assign rd_outstanding_o = r_rd;
  assign wr_outstanding_o = r_wr;
endmodule

// File: tb/tb_dram_axi_gate_ctrl.sv
// tb_dram_axi_gate_ctrl: directed self-checking bench for dram_axi_gate_ctrl
module tb_dram_axi_gate_ctrl;
  logic clk_i = 1'b0;
  logic rst_i, calib_done_i, isolate_req_i, isolate_ack_o, calib_timeout_o, calib_lost_o, protocol_err_o;
  logic [1:0] state_o;
  logic [4:0] rd_outstanding_o, wr_outstanding_o;
  logic slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
  logic slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
  logic slv_w_valid_i, slv_w_ready_o, mst_w_valid_o, mst_w_ready_i, w_last_i;
  logic mst_b_valid_i, slv_b_ready_i, mst_r_valid_i, slv_r_ready_i, r_last_i;
  int tests = 0;
  int fails = 0;
  always #5 clk_i = ~clk_i;
  dram_axi_gate_ctrl #(.MaxOutstanding(16), .CalibTimeout(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .calib_done_i(calib_done_i), .isolate_req_i(isolate_req_i),
    .isolate_ack_o(isolate_ack_o), .state_o(state_o), .calib_timeout_o(calib_timeout_o),
    .calib_lost_o(calib_lost_o), .protocol_err_o(protocol_err_o),
    .rd_outstanding_o(rd_outstanding_o), .wr_outstanding_o(wr_outstanding_o),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o), .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o), .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
    .w_last_i(w_last_i), .mst_b_valid_i(mst_b_valid_i), .slv_b_ready_i(slv_b_ready_i),
    .mst_r_valid_i(mst_r_valid_i), .slv_r_ready_i(slv_r_ready_i), .r_last_i(r_last_i)
  );
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic clear_inputs;
    {calib_done_i, isolate_req_i, slv_aw_valid_i, mst_aw_ready_i, slv_ar_valid_i, mst_ar_ready_i} = '0;
    {slv_w_valid_i, mst_w_ready_i, w_last_i, mst_b_valid_i, slv_b_ready_i, mst_r_valid_i, slv_r_ready_i, r_last_i} = '0;
  endtask
  task automatic do_reset;
    rst_i = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst_i = 1'b0;
  endtask
  task automatic go_run;
    do_reset();
    calib_done_i = 1'b1;
    tick();
  endtask
  task automatic test_reset;
    rst_i = 1'b1;
    clear_inputs();
    {slv_aw_valid_i, mst_aw_ready_i, slv_ar_valid_i, mst_ar_ready_i, slv_w_valid_i, mst_w_ready_i} = '1;
    tick();
    tick();
    tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    tests++; if ({rd_outstanding_o, wr_outstanding_o} !== 10'd0) begin fails++; $display("FAIL reset_counts got rd=%0d wr=%0d exp 0", rd_outstanding_o, wr_outstanding_o); end
    tests++; if ({isolate_ack_o, calib_timeout_o, calib_lost_o, protocol_err_o} !== 4'd0) begin fails++; $display("FAIL reset_flags got=%b exp=0000", {isolate_ack_o, calib_timeout_o, calib_lost_o, protocol_err_o}); end
    tests++; if ({mst_aw_valid_o, slv_aw_ready_o, mst_ar_valid_o, slv_ar_ready_o, mst_w_valid_o, slv_w_ready_o} !== 6'd0) begin fails++; $display("FAIL reset_gates got=%b exp=000000", {mst_aw_valid_o, slv_aw_ready_o, mst_ar_valid_o, slv_ar_ready_o, mst_w_valid_o, slv_w_ready_o}); end
  endtask
  task automatic test_calib_gate;
    do_reset();
    {slv_aw_valid_i, mst_aw_ready_i, slv_ar_valid_i, mst_ar_ready_i} = '1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      tests++; if ({mst_aw_valid_o, mst_ar_valid_o, state_o} !== 4'd0) begin fails++; $display("FAIL calib_block cyc=%0d got=%b exp=0000", i, {mst_aw_valid_o, mst_ar_valid_o, state_o}); end
      if (i == 62) begin tests++; if (calib_timeout_o !== 1'b0) begin fails++; $display("FAIL timeout_early got=%b exp=0", calib_timeout_o); end end
      if (i == 63) begin tests++; if (calib_timeout_o !== 1'b1) begin fails++; $display("FAIL timeout_at_63 got=%b exp=1", calib_timeout_o); end end
    end
    tests++; if (calib_timeout_o !== 1'b1) begin fails++; $display("FAIL timeout_sticky got=%b exp=1", calib_timeout_o); end
    {slv_aw_valid_i, slv_ar_valid_i} = '0;
    calib_done_i = 1'b1;
    tick();
    tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL calib_to_run got=%0d exp=1", state_o); end
    slv_aw_valid_i = 1'b1;
    #1;
    tests++; if ({mst_aw_valid_o, slv_aw_ready_o} !== 2'b11) begin fails++; $display("FAIL aw_zero_latency got=%b exp=11", {mst_aw_valid_o, slv_aw_ready_o}); end
    tick();
    slv_aw_valid_i = 1'b0;
    tests++; if (wr_outstanding_o !== 5'd1) begin fails++; $display("FAIL first_aw_count got=%0d exp=1", wr_outstanding_o); end
    tests++; if (calib_timeout_o !== 1'b1) begin fails++; $display("FAIL timeout_sticky_run got=%b exp=1", calib_timeout_o); end
  endtask
  task automatic test_ar_limit;
    go_run();
    {slv_ar_valid_i, mst_ar_ready_i} = '1;
    repeat (16) tick();
    tests++; if (rd_outstanding_o !== 5'd16) begin fails++; $display("FAIL ar_full_count got=%0d exp=16", rd_outstanding_o); end
    tests++; if ({slv_ar_ready_o, mst_ar_valid_o} !== 2'b00) begin fails++; $display("FAIL ar_full_stall got=%b exp=00", {slv_ar_ready_o, mst_ar_valid_o}); end
    {mst_r_valid_i, slv_r_ready_i, r_last_i} = '1;
    tick();
    {mst_r_valid_i, slv_r_ready_i, r_last_i} = '0;
    #1;
    tests++; if (rd_outstanding_o !== 5'd15) begin fails++; $display("FAIL ar_after_r got=%0d exp=15", rd_outstanding_o); end
    tests++; if (slv_ar_ready_o !== 1'b1) begin fails++; $display("FAIL ar_reopen got=%b exp=1", slv_ar_ready_o); end
    tick();
    slv_ar_valid_i = 1'b0;
    tests++; if (rd_outstanding_o !== 5'd16) begin fails++; $display("FAIL ar_17th_accepted got=%0d exp=16", rd_outstanding_o); end
  endtask
  task automatic test_isolate_drain;
    go_run();
    {slv_aw_valid_i, mst_aw_ready_i} = '1;
    tick();
    tick();
    slv_aw_valid_i = 1'b0;
    tests++; if (wr_outstanding_o !== 5'd2) begin fails++; $display("FAIL iso_two_aw got=%0d exp=2", wr_outstanding_o); end
    {slv_w_valid_i, mst_w_ready_i} = '1;
    for (int b = 1; b <= 3; b++) tick();
    slv_w_valid_i = 1'b0;
    isolate_req_i = 1'b1;
    tick();
    tests++; if (state_o !== 2'd2) begin fails++; $display("FAIL iso_to_drain got=%0d exp=2", state_o); end
    {slv_ar_valid_i, mst_ar_ready_i, slv_aw_valid_i} = '1;
    #1;
    tests++; if ({mst_ar_valid_o, slv_ar_ready_o, mst_aw_valid_o} !== 3'b000) begin fails++; $display("FAIL drain_block_new got=%b exp=000", {mst_ar_valid_o, slv_ar_ready_o, mst_aw_valid_o}); end
    slv_w_valid_i = 1'b1;
    for (int b = 4; b <= 8; b++) begin
      w_last_i = (b == 4 || b == 8);
      #1;
      tests++; if ({mst_w_valid_o, slv_w_ready_o} !== 2'b11) begin fails++; $display("FAIL drain_w_beat%0d got=%b exp=11", b, {mst_w_valid_o, slv_w_ready_o}); end
      tick();
    end
    w_last_i = 1'b0;
    #1;
    tests++; if (slv_w_ready_o !== 1'b0) begin fails++; $display("FAIL w_without_aw got=%b exp=0", slv_w_ready_o); end
    slv_w_valid_i = 1'b0;
    tests++; if (state_o !== 2'd2) begin fails++; $display("FAIL drain_wait_b got=%0d exp=2", state_o); end
    {mst_b_valid_i, slv_b_ready_i} = '1;
    tick();
    tick();
    {mst_b_valid_i, slv_b_ready_i} = '0;
    tests++; if ({state_o, wr_outstanding_o} !== {2'd2, 5'd0}) begin fails++; $display("FAIL drain_last_b got state=%0d wr=%0d exp 2/0", state_o, wr_outstanding_o); end
    tick();
    tests++; if ({state_o, isolate_ack_o} !== {2'd3, 1'b1}) begin fails++; $display("FAIL isolated got state=%0d ack=%b exp 3/1", state_o, isolate_ack_o); end
    {slv_ar_valid_i, slv_aw_valid_i} = '0;
    isolate_req_i = 1'b0;
    tick();
    tests++; if ({state_o, isolate_ack_o} !== {2'd1, 1'b0}) begin fails++; $display("FAIL iso_release got state=%0d ack=%b exp 1/0", state_o, isolate_ack_o); end
  endtask
  task automatic test_counter_edges;
    go_run();
    {slv_aw_valid_i, mst_aw_ready_i} = '1;
    repeat (5) tick();
    tests++; if (wr_outstanding_o !== 5'd5) begin fails++; $display("FAIL wr_five got=%0d exp=5", wr_outstanding_o); end
    {mst_b_valid_i, slv_b_ready_i} = '1;
    tick();
    slv_aw_valid_i = 1'b0;
    tests++; if (wr_outstanding_o !== 5'd5) begin fails++; $display("FAIL aw_b_same_cycle got=%0d exp=5", wr_outstanding_o); end
    repeat (5) tick();
    tests++; if ({wr_outstanding_o, protocol_err_o} !== {5'd0, 1'b0}) begin fails++; $display("FAIL wr_drained got wr=%0d err=%b exp 0/0", wr_outstanding_o, protocol_err_o); end
    tick();
    {mst_b_valid_i, slv_b_ready_i} = '0;
    tests++; if ({wr_outstanding_o, protocol_err_o} !== {5'd0, 1'b1}) begin fails++; $display("FAIL b_underflow got wr=%0d err=%b exp 0/1", wr_outstanding_o, protocol_err_o); end
    tick();
    tests++; if (protocol_err_o !== 1'b1) begin fails++; $display("FAIL perr_sticky got=%b exp=1", protocol_err_o); end
    do_reset();
    {slv_w_valid_i, mst_w_ready_i} = '1;
    #1;
    tests++; if ({protocol_err_o, wr_outstanding_o, slv_w_ready_o} !== 7'd0) begin fails++; $display("FAIL reset_mid_burst got err=%b wr=%0d wrdy=%b exp 0/0/0", protocol_err_o, wr_outstanding_o, slv_w_ready_o); end
    clear_inputs();
  endtask
  task automatic test_calib_lost;
    go_run();
    {slv_ar_valid_i, mst_ar_ready_i} = '1;
    repeat (3) tick();
    slv_ar_valid_i = 1'b0;
    tests++; if (rd_outstanding_o !== 5'd3) begin fails++; $display("FAIL lost_three_ar got=%0d exp=3", rd_outstanding_o); end
    calib_done_i = 1'b0;
    tick();
    tests++; if ({state_o, calib_lost_o} !== {2'd2, 1'b1}) begin fails++; $display("FAIL lost_drain got state=%0d lost=%b exp 2/1", state_o, calib_lost_o); end
    {mst_r_valid_i, slv_r_ready_i, r_last_i} = '1;
    repeat (3) tick();
    {mst_r_valid_i, slv_r_ready_i, r_last_i} = '0;
    tests++; if ({state_o, rd_outstanding_o} !== {2'd2, 5'd0}) begin fails++; $display("FAIL lost_last_r got state=%0d rd=%0d exp 2/0", state_o, rd_outstanding_o); end
    tick();
    tests++; if ({state_o, calib_lost_o} !== {2'd0, 1'b1}) begin fails++; $display("FAIL lost_to_calib got state=%0d lost=%b exp 0/1", state_o, calib_lost_o); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_calib_gate();
    test_ar_limit();
    test_isolate_drain();
    test_counter_edges();
    test_calib_lost();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
